// File: rtl/tlp_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tlp_wrr_scheduler
// Brief    : Weighted round-robin scheduler between four transaction-layer
//            input FIFOs and four output FIFOs. Each cycle it pops at most
//            one input head and pushes it into the output FIFO named by the
//            head's destination field. Output almost_full flags gate the
//            transfer combinationally.
// Options  : SCHED_STRICT_PRIO0_EN - when defined, channel 0 takes the grant
//            whenever it is eligible and keeps it while it stays eligible.
// Revision : 1.0 - initial release
// ============================================================================
module tlp_wrr_scheduler #(
  parameter int WEIGHT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] weight0,
  input  logic [WEIGHT_W-1:0] weight1,
  input  logic [WEIGHT_W-1:0] weight2,
  input  logic [WEIGHT_W-1:0] weight3,
  input  logic [3:0]          empty_in,
  input  logic [1:0]          dest0,
  input  logic [1:0]          dest1,
  input  logic [1:0]          dest2,
  input  logic [1:0]          dest3,
  input  logic [3:0]          almost_full_out,
  output logic [3:0]          pop,
  output logic [3:0]          push,
  output logic [1:0]          sel,
  output logic [1:0]          state,
  output logic                idle
);

  typedef enum logic [1:0] {
    ST_CFG    = 2'd0,
    ST_INIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_gnt;
  logic [1:0]          w_gnt_nxt;
  logic [WEIGHT_W-1:0] r_cnt;
  logic [WEIGHT_W-1:0] w_cnt_nxt;
  logic [WEIGHT_W-1:0] r_weight [4];
  logic [1:0]          w_dest   [4];
  logic [3:0]          w_elig;
  logic                w_xfer;
  logic                w_found;
  logic [1:0]          w_next;

  assign w_dest[0] = dest0;
  assign w_dest[1] = dest1;
  assign w_dest[2] = dest2;
  assign w_dest[3] = dest3;

  // A channel is eligible when it has data and its target output has room.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = !empty_in[i] && !almost_full_out[w_dest[i]];
    end
  end

  // First eligible channel after the grantee, searched gnt+1 .. gnt+3.
  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_next  = r_gnt;
    idx     = r_gnt;
    for (int k = 1; k < 4; k++) begin
      idx = r_gnt + 2'(k);
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_next  = idx;
      end
    end
  end

  // Transfer gate is purely combinational so a flag change blocks it at once.
  assign w_xfer = (r_state == ST_ACTIVE) && !init && w_elig[r_gnt];

  // Pop/push steering and status outputs.
  always_comb begin
    pop  = 4'b0000;
    push = 4'b0000;
    if (w_xfer) begin
      pop[r_gnt]          = 1'b1;
      push[w_dest[r_gnt]] = 1'b1;
    end
  end

  assign sel   = r_gnt;
  assign state = r_state;
  assign idle  = (r_state != ST_ACTIVE) || (w_elig == 4'b0000);

  // Configuration FSM next-state logic; the unused encoding recovers to CFG.
  always_comb begin
    w_state_nxt = ST_CFG;
    case (r_state)
      ST_CFG:    w_state_nxt = init ? ST_INIT : ST_CFG;
      ST_INIT:   w_state_nxt = init ? ST_INIT : ST_ACTIVE;
      ST_ACTIVE: w_state_nxt = init ? ST_INIT : ST_ACTIVE;
      default:   w_state_nxt = ST_CFG;
    endcase
  end

  // Grant and burst-count update; frozen outside ACTIVE and while init blocks.
  always_comb begin
    w_gnt_nxt = r_gnt;
    w_cnt_nxt = r_cnt;
    if ((r_state == ST_ACTIVE) && !init) begin
      if (w_xfer && (r_cnt < r_weight[r_gnt])) begin
        w_cnt_nxt = r_cnt + WEIGHT_W'(1);
      end else begin
        w_cnt_nxt = '0;
        if (w_found) begin
          w_gnt_nxt = w_next;
        end
      end
`ifdef SCHED_STRICT_PRIO0_EN
      // Channel 0 overrides any burst in progress and never ends its own.
      if (w_elig[0]) begin
        w_gnt_nxt = 2'd0;
        w_cnt_nxt = '0;
      end
`endif
    end
  end

  // State, grant and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_CFG;
      r_gnt   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Weights are sampled every cycle spent in INIT and held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_weight[i] <= '0;
      end
    end else if (r_state == ST_INIT) begin
      r_weight[0] <= weight0;
      r_weight[1] <= weight1;
      r_weight[2] <= weight2;
      r_weight[3] <= weight3;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlp_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlp_wrr_scheduler
// Brief    : Directed, table-driven bench for tlp_wrr_scheduler. Each record
//            holds one cycle of inputs and the outputs expected in that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlp_wrr_scheduler;

  logic       clk;
  logic       reset;
  logic       init;
  logic [2:0] weight0, weight1, weight2, weight3;
  logic [3:0] empty_in;
  logic [1:0] dest0, dest1, dest2, dest3;
  logic [3:0] almost_full_out;
  logic [3:0] pop, push;
  logic [1:0] sel, state;
  logic       idle;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       init;
    logic [2:0] w0, w1, w2, w3;
    logic [3:0] empty;
    logic [1:0] d0, d1, d2, d3;
    logic [3:0] af;
    logic [1:0] st;
    logic [1:0] sel;
    logic [3:0] pop;
    logic [3:0] push;
    logic       idle;
  } vec_t;

  vec_t tbl [37];

  tlp_wrr_scheduler #(.WEIGHT_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .weight0        (weight0),
    .weight1        (weight1),
    .weight2        (weight2),
    .weight3        (weight3),
    .empty_in       (empty_in),
    .dest0          (dest0),
    .dest1          (dest1),
    .dest2          (dest2),
    .dest3          (dest3),
    .almost_full_out(almost_full_out),
    .pop            (pop),
    .push           (push),
    .sel            (sel),
    .state          (state),
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic i, input logic [2:0] a0, a1, a2, a3,
                              input logic [3:0] e, input logic [1:0] b0, b1, b2, b3,
                              input logic [3:0] f, input logic [1:0] s, g,
                              input logic [3:0] p, q, input logic id);
    vec_t v;
    v.init = i; v.w0 = a0; v.w1 = a1; v.w2 = a2; v.w3 = a3;
    v.empty = e; v.d0 = b0; v.d1 = b1; v.d2 = b2; v.d3 = b3; v.af = f;
    v.st = s; v.sel = g; v.pop = p; v.push = q; v.idle = id;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input vec_t v);
    chk("state", idx, {2'b00, state}, {2'b00, v.st});
    chk("sel",   idx, {2'b00, sel},   {2'b00, v.sel});
    chk("pop",   idx, pop,            v.pop);
    chk("push",  idx, push,           v.push);
    chk("idle",  idx, {3'b000, idle}, {3'b000, v.idle});
  endtask

  // Drive one cycle of inputs away from the rising edge, then compare.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    init = v.init;
    weight0 = v.w0; weight1 = v.w1; weight2 = v.w2; weight3 = v.w3;
    empty_in = v.empty;
    dest0 = v.d0; dest1 = v.d1; dest2 = v.d2; dest3 = v.d3;
    almost_full_out = v.af;
    #1;
    check_outs(idx, v);
  endtask

  initial begin
    vec_t h;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    init = 1'b0;
    weight0 = 3'd0; weight1 = 3'd0; weight2 = 3'd0; weight3 = 3'd0;
    empty_in = 4'b1111;
    dest0 = 2'd0; dest1 = 2'd0; dest2 = 2'd0; dest3 = 2'd0;
    almost_full_out = 4'b0000;

    //          init w0 w1 w2 w3 empty    d0 d1 d2 d3 af      st sel pop      push     idle
    // configuration CFG -> INIT -> ACTIVE with all weights 0
    tbl[0]  = mk(1, 0, 0, 0, 0, 4'b1111, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
    tbl[1]  = mk(1, 0, 0, 0, 0, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1);
    // fair round robin 0,1,2,3,0
    tbl[3]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 2, 1, 4'b0010, 4'b0001, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 2, 2, 4'b0100, 4'b0001, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 2, 3, 4'b1000, 4'b0001, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    // reconfigure weight0=2 (grant rests on 1)
    tbl[8]  = mk(1, 2, 0, 0, 0, 4'b1111, 0, 0, 0, 0, 4'b0000, 2, 1, 4'b0000, 4'b0000, 1);
    tbl[9]  = mk(0, 2, 0, 0, 0, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 1);
    // weighted pattern on channels 0 and 1: 1,0,0,0,1,0,0,0,1
    tbl[10] = mk(0, 2, 0, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b0000, 2, 1, 4'b0010, 4'b0001, 0);
    tbl[11] = mk(0, 2, 0, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[12] = mk(0, 2, 0, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[13] = mk(0, 2, 0, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[14] = mk(0, 2, 0, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b0000, 2, 1, 4'b0010, 4'b0001, 0);
    tbl[15] = mk(0, 2, 0, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[16] = mk(0, 2, 0, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[17] = mk(0, 2, 0, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[18] = mk(0, 2, 0, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b0000, 2, 1, 4'b0010, 4'b0001, 0);
    // backpressure: dest1=2, almost_full_out[2] while grant reaches 1
    tbl[19] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[20] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[21] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[22] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0100, 2, 1, 4'b0000, 4'b0000, 0);
    tbl[23] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0100, 2, 2, 4'b0100, 4'b0001, 0);
    tbl[24] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0000, 2, 3, 4'b1000, 4'b0001, 0);
    tbl[25] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[26] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[27] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[28] = mk(0, 2, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 4'b0000, 2, 1, 4'b0010, 4'b0100, 0);
    // reconfigure weight3=3, then FIFO 3 holds a single entry
    tbl[29] = mk(1, 0, 0, 0, 3, 4'b1111, 0, 0, 0, 0, 4'b0000, 2, 2, 4'b0000, 4'b0000, 1);
    tbl[30] = mk(0, 0, 0, 0, 3, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 2, 4'b0000, 4'b0000, 1);
    tbl[31] = mk(0, 0, 0, 0, 3, 4'b0111, 0, 0, 0, 0, 4'b0000, 2, 2, 4'b0000, 4'b0000, 0);
    tbl[32] = mk(0, 0, 0, 0, 3, 4'b0111, 0, 0, 0, 0, 4'b0000, 2, 3, 4'b1000, 4'b0001, 0);
    tbl[33] = mk(0, 0, 0, 0, 3, 4'b1111, 0, 0, 0, 0, 4'b0000, 2, 3, 4'b0000, 4'b0000, 1);
    tbl[34] = mk(0, 0, 0, 0, 3, 4'b1110, 0, 0, 0, 0, 4'b0000, 2, 3, 4'b0000, 4'b0000, 0);
    tbl[35] = mk(0, 0, 0, 0, 3, 4'b1110, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);
    tbl[36] = mk(0, 0, 0, 0, 3, 4'b1110, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0);

    // reset state while reset is held
    #1;
    chk("rst_state", -1, {2'b00, state}, 4'd0);
    chk("rst_sel",   -1, {2'b00, sel},   4'd0);
    chk("rst_pop",   -1, pop,            4'b0000);
    chk("rst_push",  -1, push,           4'b0000);
    chk("rst_idle",  -1, {3'b000, idle}, 4'd1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 37; i++) begin
      apply(i, tbl[i]);
    end

    // asynchronous reset mid-burst while pop=0001: outputs clear before any edge
    #1;
    reset = 1'b0;
    #1;
    chk("arst_state", 100, {2'b00, state}, 4'd0);
    chk("arst_sel",   100, {2'b00, sel},   4'd0);
    chk("arst_pop",   100, pop,            4'b0000);
    chk("arst_push",  100, push,           4'b0000);
    chk("arst_idle",  100, {3'b000, idle}, 4'd1);
    @(negedge clk);
    reset = 1'b1;

    // state 0 -> 1 -> 2 after release, latching weight2=3
    h = mk(1, 0, 0, 3, 0, 4'b1111, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1); apply(200, h);
    h = mk(0, 0, 0, 3, 0, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1); apply(201, h);
    // grant 0 empty, channel 2 has data: bubble then burst on 2
    h = mk(0, 0, 0, 3, 0, 4'b1011, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0000, 4'b0000, 0); apply(202, h);
    h = mk(0, 0, 0, 3, 0, 4'b1011, 0, 0, 0, 0, 4'b0000, 2, 2, 4'b0100, 4'b0001, 0); apply(203, h);
    // channel 0 becomes eligible while gnt=2, cnt=1
    h = mk(0, 0, 0, 3, 0, 4'b1010, 0, 0, 0, 0, 4'b0000, 2, 2, 4'b0100, 4'b0001, 0); apply(204, h);
`ifdef SCHED_STRICT_PRIO0_EN
    h = mk(0, 0, 0, 3, 0, 4'b1010, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0); apply(205, h);
    h = mk(0, 0, 0, 3, 0, 4'b1010, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0); apply(206, h);
    h = mk(0, 0, 0, 3, 0, 4'b1010, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0); apply(207, h);
`else
    h = mk(0, 0, 0, 3, 0, 4'b1010, 0, 0, 0, 0, 4'b0000, 2, 2, 4'b0100, 4'b0001, 0); apply(205, h);
    h = mk(0, 0, 0, 3, 0, 4'b1010, 0, 0, 0, 0, 4'b0000, 2, 2, 4'b0100, 4'b0001, 0); apply(206, h);
    h = mk(0, 0, 0, 3, 0, 4'b1010, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0001, 4'b0001, 0); apply(207, h);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlp_wrr_scheduler.md
# tlp_wrr_scheduler

Weighted round-robin scheduler for the transaction-layer datapath between the four input FIFOs and the four output FIFOs. Each cycle it picks at most one input FIFO, pops its head, steers it through the crossbar mux and pushes it into the output FIFO named by the head's destination field. Output FIFOs apply backpressure through `almost_full`. A small FSM gates transfers during configuration.

## Interface
Parameters:
- `WEIGHT_W`, default 3: width of each per-channel burst weight.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state immediately.
- `init`, input, 1: configuration request; while high, weights are (re)latched.
- `weight0`..`weight3`, input, WEIGHT_W each: burst weight per input channel. A channel may make weight+1 consecutive pops.
- `empty_in`, input, 4: `empty` flags of input FIFOs 0..3.
- `dest0`..`dest3`, input, 2 each: destination field (data bits [9:8]) at the head of input FIFO 0..3.
- `almost_full_out`, input, 4: `almost_full` flags of output FIFOs 0..3.
- `pop`, output, 4: one-hot pop to the input FIFOs.
- `push`, output, 4: one-hot push to the output FIFOs.
- `sel`, output, 2: crossbar select, equal to the current grantee.
- `state`, output, 2: FSM state (0=CFG, 1=INIT, 2=ACTIVE).
- `idle`, output, 1: high in ACTIVE when no channel is eligible; also high outside ACTIVE.

## Operation
FSM:
- CFG → INIT when `init`=1.
- INIT: latches `weight0`..`weight3` every cycle. INIT → ACTIVE when `init`=0.
- ACTIVE → INIT when `init`=1.
- Encoding 3 is unreachable; if entered, the next state is CFG.

Eligibility and transfer:
- Channel i is eligible when `!empty_in[i] && !almost_full_out[dest_i]`.
- Transfer occurs when state=ACTIVE, `init`=0 and the grantee `gnt` is eligible.
- On a transfer: `pop[gnt]`=1 and `push[dest_gnt]`=1. Otherwise `pop` and `push` are 0.

Grant register `gnt` (2 b) and burst counter `cnt` (WEIGHT_W b):
- **Transfer with `cnt` < weight[gnt]:** `cnt` increments and `gnt` holds.
- **Transfer with `cnt` = weight[gnt]:** `gnt` moves to the first eligible channel in order gnt+1, gnt+2, gnt+3 (mod 4). If none is eligible, `gnt` holds. `cnt` clears to 0 in both cases.
- **Grantee not eligible:** `gnt` moves to the first eligible channel in order gnt+1..gnt+3. If none, `gnt` holds. `cnt` clears.
- Outside ACTIVE, `gnt` and `cnt` hold their values.
- `sel` = `gnt` at all times.
- Weights update only in INIT. Their value in ACTIVE is always the last value latched.

## Timing
- Reset values: state=CFG, `gnt`=0, `cnt`=0, all weights=0, `pop`=0, `push`=0, `sel`=0, `idle`=1.
- `pop`, `push` and `idle` are combinational from registered `gnt`/state and the live flags. There is zero-cycle latency from a flag change to the pop gate, so the block never pops an empty FIFO or pushes into an almost-full one.
- `gnt`, `cnt` and state update on the clock edge. A newly selected channel is served from the next cycle, so a switch costs at most one bubble cycle.
- Popping the last entry sets `empty_in[i]`=1 the following cycle. The grant then moves with no extra pop.
- Asserting `init` in ACTIVE blocks transfers in that same cycle. Data already pushed is unaffected.
- `reset` asserted mid-burst: all outputs reach reset values asynchronously. No partial transfer is retained.

## Configuration
- `SCHED_STRICT_PRIO0_EN` defined: channel 0 has strict priority. Whenever channel 0 is eligible and `gnt`≠0, the next edge forces `gnt`=0 and `cnt`=0 regardless of the burst count. Channel 0 keeps the grant while eligible and ignores `weight0`.
- Not defined: pure weighted round-robin as described in Operation.

## Test plan
- **Reset/config:** assert `reset`=0 mid-ACTIVE with `pop`=0001 → `pop`=0, `push`=0, `state`=0, `sel`=0, `idle`=1 immediately. After release with `init` 1 then 0 → state goes 0→1→2.
- **Fair RR:** all weights 0, all inputs non-empty, all dest=0, `almost_full_out`=0 → pop sequence 0,1,2,3,0 on consecutive transfers, `push`=0001 every transfer.
- **Weights:** weight0=2, weight1=0, channels 0 and 1 full, others empty → pattern 0,0,0,1,0,0,0,1.
- **Backpressure:** dest1=2 and `almost_full_out[2]` raised while `gnt`=1 → `pop[1]`=0 that same cycle, grant moves to the next eligible channel. Clearing the flag lets channel 1 be served on its next turn.
- **Empty boundary:** FIFO 3 holds 1 entry, weight3=3 → exactly one `pop[3]`, then the grant moves on. No pop while `empty_in[3]`=1.
- **Macro:** with `SCHED_STRICT_PRIO0_EN`, channel 0 becomes eligible while `gnt`=2, `cnt`=1 → `gnt`=0 on the next edge, and only channel 0 is popped while it stays eligible. Without the macro, channel 2 finishes its burst first.
